rx_frame_parser: RTL

Byte-level framing stage directly downstream of the UART receiver. It consumes the receiver's 8-bit `rx_data` and `rx_done_sig` strobe, hunts for a sync byte, and collects a length-prefixed payload into an internal buffer. It verifies an 8-bit additive checksum and presents each good frame to the application through a hold-until-acknowledged read port.

---
 rtl/rx_frame_pkg.sv | 9 +
 rtl/rx_frame_buf.sv | 30 +++
 rtl/rx_frame_parser.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rx_frame_pkg.sv
// rx_frame_pkg: shared FSM states and default constants for the rx frame parser
package rx_frame_pkg;

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CSUM, HOLD} state_t;

    localparam logic [7:0] SYNC_BYTE_DEF   = 8'h55;
    localparam int         TIMEOUT_CYC_DEF = 50000;

endpackage

// File: rtl/rx_frame_buf.sv
// rx_frame_buf: payload byte array with one write port and one registered read port
module rx_frame_buf #(
    parameter int MAX_LEN = 16,
    parameter int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem_q [MAX_LEN];
    logic [7:0] rd_data_q;

    // Storage has no reset so an aborted frame leaves the old contents in place
    always_ff @(posedge clk) begin
        if (we) mem_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/rx_frame_parser.sv
// rx_frame_parser: sync-hunting, length-prefixed, checksummed frame collector.
// Define RX_FRAME_TIMEOUT_EN to build the inter-byte timeout.
module rx_frame_parser
    import rx_frame_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int        LW          = $clog2(MAX_LEN + 1),
    localparam int        AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_done_sig,
    output logic          frame_valid,
    output logic [LW-1:0] frame_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          frame_ack,
    output logic          err_csum,
    output logic          err_len,
    output logic          err_drop,
    output logic          err_timeout
);

    state_t        state_q, state_d;
    logic          done_q;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [7:0]    sum_q, sum_d;
    logic [LW-1:0] frame_len_q, frame_len_d;
    logic          err_csum_q, err_csum_d;
    logic          err_len_q, err_len_d;
    logic          err_drop_q, err_drop_d;
    logic          stb, we, timeout_hit;

    assign stb = rx_done_sig & ~done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        sum_d       = sum_q;
        frame_len_d = frame_len_q;
        err_csum_d  = 1'b0;
        err_len_d   = 1'b0;
        err_drop_d  = 1'b0;
        we          = 1'b0;
        if (timeout_hit) begin
            state_d = IDLE;
        end else if (stb) begin
            case (state_q)
                IDLE: state_d = (rx_data == SYNC_BYTE) ? LEN : IDLE;
                LEN: begin
                    if (rx_data > 8'(MAX_LEN)) begin
                        err_len_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        len_d   = LW'(rx_data);
                        sum_d   = rx_data;
                        cnt_d   = '0;
                        state_d = (rx_data == 8'h00) ? CSUM : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    we      = 1'b1;
                    sum_d   = sum_q + rx_data;
                    cnt_d   = cnt_q + AW'(1);
                    state_d = (cnt_q == AW'(len_q - LW'(1))) ? CSUM : PAYLOAD;
                end
                CSUM: begin
                    if (rx_data == sum_q) begin
                        frame_len_d = len_q;
                        state_d     = HOLD;
                    end else begin
                        err_csum_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
                HOLD:    err_drop_d = 1'b1;
                default: state_d = IDLE;
            endcase
        end
        // Release wins over anything strobed in the same cycle; that byte is dropped above
        if (state_q == HOLD && frame_ack) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            done_q      <= 1'b1;
            cnt_q       <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            frame_len_q <= '0;
            err_csum_q  <= 1'b0;
            err_len_q   <= 1'b0;
            err_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= rx_done_sig;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            frame_len_q <= frame_len_d;
            err_csum_q  <= err_csum_d;
            err_len_q   <= err_len_d;
            err_drop_q  <= err_drop_d;
        end
    end

`ifdef RX_FRAME_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] to_q, to_d;
    logic          err_timeout_q;
    logic          in_frame;

    always_comb begin
        in_frame    = state_q inside {LEN, PAYLOAD, CSUM};
        timeout_hit = in_frame && !stb && (to_q == TW'(TIMEOUT_CYC - 1));
        to_d        = (!in_frame || stb || timeout_hit) ? '0 : to_q + TW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_q          <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            to_q          <= to_d;
            err_timeout_q <= timeout_hit;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYC > 0);
    assign timeout_hit    = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    rx_frame_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wr_addr (cnt_q),
        .wr_data (rx_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign frame_valid = (state_q == HOLD);
    assign frame_len   = frame_len_q;
    assign err_csum    = err_csum_q;
    assign err_len     = err_len_q;
    assign err_drop    = err_drop_q;

endmodule
